// File: rtl/reg_bank_pkg.sv
// Shared op encoding and next-value/wrap helper for counter-style registers.
// Latency: pure functions and types, no state.
// Backpressure: none, callers own all flow control.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_INC   = 2'b01,
        OP_DEC   = 2'b10,
        OP_CLEAR = 2'b11
    } wr_op_e;

    // Widest register the helper supports; narrower callers zero-extend.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        word_t val;
        logic  wrap;
    } op_res_t;

    // Next value and wrap flag for a register of 'width' bits.
    // Arithmetic is modulo 2^width; the upper bits of val are always zero.
    function automatic op_res_t op_next(input wr_op_e op, input word_t old,
                                        input word_t data, input int unsigned width);
        word_t   mask;
        op_res_t r;
        mask   = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
        r.val  = '0;
        r.wrap = 1'b0;
        case (op)
            OP_LOAD:  r.val = data & mask;
            OP_INC: begin
                r.val  = (old + word_t'(1)) & mask;
                r.wrap = ((old & mask) == mask);
            end
            OP_DEC: begin
                r.val  = (old - word_t'(1)) & mask;
                r.wrap = ((old & mask) == '0);
            end
            OP_CLEAR: r.val = '0;
            default:  r.val = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/register_bank_plus_cell.sv
// One WIDTH-bit register with load/inc/dec/clear; exposes stored, next and wrap.
// Latency: state updates on the rising edge when sel=1; nxt/wrap_cond are combinational.
// Backpressure: none, sel is a single-cycle strobe.
module register_plus_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  wr_op_e           op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_cond
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    op_res_t          res;

    // Candidate next value is always computed so the top can bypass it to readers.
    always_comb begin
        res = op_next(op, word_t'(q_q), word_t'(data), WIDTH);
    end

    assign nxt       = res.val[WIDTH-1:0];
    assign wrap_cond = res.wrap;
    assign q         = q_q;

    // Bits above WIDTH are zero by construction of op_next.
    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res.val[MAX_W-1:WIDTH];
    end

    // Only the selected cell takes the new value; everything else holds.
    always_comb begin
        q_d = q_q;
        if (sel) begin
            q_d = nxt;
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/register_bank_plus.sv
// DEPTH x WIDTH register file: one op write port, two gated read ports, one monitor port.
// Latency: writes land on the rising edge; reads are zero-latency (optionally bypassed); wrap is one cycle late.
// Backpressure: none, every write strobe is accepted or (out-of-range) dropped in its own cycle.
module register_bank_plus
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [WIDTH-1:0]  rd0_data,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [WIDTH-1:0]  rd1_data,
    input  logic [ADDR_W-1:0] mon_addr,
    output logic [WIDTH-1:0]  mon_data,
    output logic              wrap
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    wr_op_e           op;
    logic             wr_valid;
    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] wcond;
    logic [WIDTH-1:0] q_arr   [DEPTH];
    logic [WIDTH-1:0] nxt_arr [DEPTH];
    logic             wrap_q;
    logic             wrap_d;

    assign op       = wr_op_e'(wr_op);
    assign wr_valid = wr_en && ({1'b0, wr_addr} < DEPTH_C);

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        assign sel[g] = wr_valid && (wr_addr == ADDR_W'(g));

        register_plus_cell #(.WIDTH(WIDTH)) u_cell (
            .clk       (clk),
            .rst_n     (rst),
            .sel       (sel[g]),
            .op        (op),
            .data      (wr_data),
            .q         (q_arr[g]),
            .nxt       (nxt_arr[g]),
            .wrap_cond (wcond[g])
        );
    end

    // Read port 0: zero when disabled or out of range; sel[i] marks a same-cycle write hit.
    always_comb begin
        rd0_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd0_en && (rd0_addr == ADDR_W'(i))) begin
                rd0_data = ((BYPASS != 0) && sel[i]) ? nxt_arr[i] : q_arr[i];
            end
        end
    end

    // Read port 1: identical behaviour, independent of port 0.
    always_comb begin
        rd1_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd1_en && (rd1_addr == ADDR_W'(i))) begin
                rd1_data = ((BYPASS != 0) && sel[i]) ? nxt_arr[i] : q_arr[i];
            end
        end
    end

    // Monitor always shows stored contents so it never depends on the write port.
    always_comb begin
        mon_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mon_addr == ADDR_W'(i)) begin
                mon_data = q_arr[i];
            end
        end
    end

    // Wrap is raised only when the selected cell actually wraps this cycle.
    always_comb begin
        wrap_d = |(sel & wcond);
    end

    // Registered wrap pulse, cleared asynchronously with the bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_register_bank_plus.sv
// Bench for register_bank_plus: three configurations driven by the same stimulus.
// Latency: model commits on each rising edge; outputs sampled at the falling edge.
// Backpressure: not applicable.
module tb_register_bank_plus;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_op;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd0_en, rd1_en;
    logic [2:0] rd0_addr, rd1_addr, mon_addr;

    logic [7:0] a_rd0, a_rd1, a_mon, b_rd0, b_rd1, b_mon;
    logic [3:0] c_rd0, c_rd1, c_mon;
    logic       a_wrap, b_wrap, c_wrap;

    int checks   = 0;
    int failures = 0;

    // Reference state: plain integer array per configuration, plus the expected wrap output.
    int mdl [3][8];
    int wrap_exp [3];

    always #5 clk = ~clk;

    // a: 8x8 bypass, b: 8x8 no bypass, c: 5x4 bypass
    register_bank_plus u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_rd0),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_rd1),
        .mon_addr(mon_addr), .mon_data(a_mon), .wrap(a_wrap)
    );

    register_bank_plus #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_rd0),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_rd1),
        .mon_addr(mon_addr), .mon_data(b_mon), .wrap(b_wrap)
    );

    register_bank_plus #(.WIDTH(4), .DEPTH(5)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(c_rd0),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(c_rd1),
        .mon_addr(mon_addr), .mon_data(c_mon), .wrap(c_wrap)
    );

    function automatic int dep(input int k); return (k == 2) ? 5 : 8; endfunction
    function automatic int wid(input int k); return (k == 2) ? 4 : 8; endfunction
    function automatic bit byp(input int k); return (k != 1); endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result of applying an op to a value, in modular arithmetic on the register width.
    function automatic int op_result(input int k, input int op, input int old, input int data);
        int m;
        m = 1 << wid(k);
        case (op)
            0:       return data % m;
            1:       return (old + 1) % m;
            2:       return (old + m - 1) % m;
            default: return 0;
        endcase
    endfunction

    function automatic int op_wraps(input int k, input int op, input int old);
        int m;
        m = 1 << wid(k);
        return ((op == 1 && old == m - 1) || (op == 2 && old == 0)) ? 1 : 0;
    endfunction

    function automatic bit wr_hits(input int k);
        return wr_en && (int'(wr_addr) < dep(k));
    endfunction

    function automatic int exp_rd(input int k, input logic en, input int addr);
        if (!en || addr >= dep(k)) return 0;
        if (byp(k) && wr_hits(k) && addr == int'(wr_addr))
            return op_result(k, int'(wr_op), mdl[k][addr], int'(wr_data));
        return mdl[k][addr];
    endfunction

    function automatic int exp_mon(input int k);
        return (int'(mon_addr) < dep(k)) ? mdl[k][mon_addr] : 0;
    endfunction

    task automatic check_all();
        int g0, g1, gm, gw;
        for (int k = 0; k < 3; k++) begin
            g0 = (k == 0) ? int'(a_rd0)  : (k == 1) ? int'(b_rd0)  : int'(c_rd0);
            g1 = (k == 0) ? int'(a_rd1)  : (k == 1) ? int'(b_rd1)  : int'(c_rd1);
            gm = (k == 0) ? int'(a_mon)  : (k == 1) ? int'(b_mon)  : int'(c_mon);
            gw = (k == 0) ? int'(a_wrap) : (k == 1) ? int'(b_wrap) : int'(c_wrap);
            chk($sformatf("d%0d_rd0@%0d", k, rd0_addr), g0, exp_rd(k, rd0_en, int'(rd0_addr)));
            chk($sformatf("d%0d_rd1@%0d", k, rd1_addr), g1, exp_rd(k, rd1_en, int'(rd1_addr)));
            chk($sformatf("d%0d_mon@%0d", k, mon_addr), gm, exp_mon(k));
            chk($sformatf("d%0d_wrap", k), gw, wrap_exp[k]);
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        int nv [3];
        int nw [3];
        @(negedge clk);
        check_all();
        for (int k = 0; k < 3; k++) begin
            nw[k] = 0;
            nv[k] = mdl[k][wr_addr];
            if (wr_hits(k)) begin
                nv[k] = op_result(k, int'(wr_op), mdl[k][wr_addr], int'(wr_data));
                nw[k] = op_wraps(k, int'(wr_op), mdl[k][wr_addr]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (wr_hits(k)) mdl[k][wr_addr] = nv[k];
            wrap_exp[k] = nw[k];
        end
    endtask

    task automatic set_wr(input logic en, input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data);
        wr_en = en; wr_op = op; wr_addr = addr; wr_data = data;
    endtask

    task automatic set_rd(input logic e0, input logic [2:0] a0, input logic e1, input logic [2:0] a1,
                          input logic [2:0] m);
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1; mon_addr = m;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            wrap_exp[k] = 0;
            for (int i = 0; i < 8; i++) mdl[k][i] = 0;
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        set_wr(1'b0, 2'd0, 3'd0, 8'h00);
        set_rd(1'b0, 3'd0, 1'b0, 3'd0, 3'd0);

        // Reset state, sweeping both the read port and the monitor.
        for (int a = 0; a < 8; a++) begin
            set_rd(1'b1, 3'(a), 1'b0, 3'd0, 3'(a));
            #1;
            chk($sformatf("rst_rd0@%0d", a), a_rd0, 0);
            chk($sformatf("rst_mon@%0d", a), a_mon, 0);
            chk("rst_wrap", a_wrap, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            set_rd(1'b1, 3'(a), 1'b1, 3'(7 - a), 3'(a));
            step();
        end

        // Load then read back with port 1 disabled on the same address.
        set_wr(1'b1, 2'd0, 3'd3, 8'hA5);
        step();
        set_wr(1'b0, 2'd0, 3'd0, 8'h00);
        set_rd(1'b1, 3'd3, 1'b0, 3'd3, 3'd3);
        #1;
        chk("load_rd0", a_rd0, 8'hA5);
        chk("dis_rd1", a_rd1, 0);
        chk("small_load_rd0", c_rd0, 4'h5);
        step();

        // Counter wrap up and back down on r1.
        set_rd(1'b1, 3'd1, 1'b0, 3'd0, 3'd1);
        set_wr(1'b1, 2'd0, 3'd1, 8'hFE);
        step();
        set_wr(1'b1, 2'd1, 3'd1, 8'h00);
        step();
        chk("inc1_mon", a_mon, 8'hFF);
        chk("inc1_wrap", a_wrap, 0);
        step();
        chk("inc2_mon", a_mon, 8'h00);
        chk("inc2_wrap", a_wrap, 1);
        set_wr(1'b1, 2'd2, 3'd1, 8'h00);
        step();
        chk("dec_mon", a_mon, 8'hFF);
        chk("dec_wrap", a_wrap, 1);
        set_wr(1'b0, 2'd0, 3'd0, 8'h00);
        step();
        chk("idle_wrap", a_wrap, 0);

        // Same-cycle bypass versus stored-only read.
        set_wr(1'b1, 2'd0, 3'd2, 8'h10);
        step();
        set_wr(1'b1, 2'd1, 3'd2, 8'h00);
        set_rd(1'b0, 3'd0, 1'b1, 3'd2, 3'd2);
        #1;
        chk("byp_rd1", a_rd1, 8'h11);
        chk("byp_mon", a_mon, 8'h10);
        chk("nobyp_rd1", b_rd1, 8'h10);
        step();
        set_wr(1'b0, 2'd0, 3'd0, 8'h00);
        #1;
        chk("post_rd1", a_rd1, 8'h11);
        chk("post_mon", a_mon, 8'h11);
        chk("nobyp_post_rd1", b_rd1, 8'h11);
        step();

        // Out-of-range writes and reads on the 5-deep bank, then clear after load.
        set_wr(1'b1, 2'd0, 3'd6, 8'h07);
        set_rd(1'b1, 3'd5, 1'b1, 3'd6, 3'd7);
        step();
        chk("oor_wrap", c_wrap, 0);
        chk("oor_rd1", c_rd1, 0);
        set_wr(1'b1, 2'd1, 3'd7, 8'h00);
        step();
        set_wr(1'b1, 2'd0, 3'd4, 8'h0F);
        set_rd(1'b1, 3'd4, 1'b1, 3'd6, 3'd4);
        step();
        chk("small_load_r4", c_mon, 4'hF);
        set_wr(1'b1, 2'd3, 3'd4, 8'h00);
        step();
        chk("small_clear_r4", c_mon, 0);

        // Asynchronous reset in the middle of a pending write.
        set_wr(1'b1, 2'd0, 3'd0, 8'h33);
        set_rd(1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
        step();
        chk("pre_rst_mon", a_mon, 8'h33);
        set_wr(1'b1, 2'd0, 3'd0, 8'h44);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_mon_a", a_mon, 0);
        chk("arst_mon_b", b_mon, 0);
        chk("arst_wrap", a_wrap, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_mon", a_mon, 0);
        @(negedge clk);
        rst = 1'b1;
        set_wr(1'b0, 2'd0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("rel_mon", a_mon, 0);
        chk("rel_rd0", a_rd0, 0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            int pick;
            logic [7:0] d;
            pick = int'($urandom_range(0, 3));
            d = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : (pick == 2) ? 8'h0F : 8'($urandom);
            set_wr(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), d);
            set_rd(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) rd0_addr = wr_addr;
            if ($urandom_range(0, 3) == 0) rd1_addr = wr_addr;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank_plus.md
Name: register_bank_plus

Overview:
- Parametrised successor to the single 8-bit save/load register component: a bank of DEPTH registers, each WIDTH bits wide.
- One write port with an operation select (load/increment/decrement/clear).
- Two enable-gated read ports, plus one always-on monitor port.
- A registered wrap/overflow pulse.
- Used as the general-purpose register file for the team's CPU datapaths; replaces hand-wired arrays of single registers.

Parameters:
- WIDTH, 8, data width of each register (≥1).
- DEPTH, 8, number of registers (≥2; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; never overridden).
- BYPASS, 1, 1 = read ports return the value being written in the same cycle; 0 = read ports return stored contents only.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wr_en  in  1  write/operate strobe for this cycle.
- wr_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- wr_addr  in  ADDR_W  target register.
- wr_data  in  WIDTH  data for LOAD; ignored for other ops.
- rd0_en  in  1  read port 0 enable.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  WIDTH  read port 0 data; 0 when disabled.
- rd1_en  in  1  read port 1 enable.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  WIDTH  read port 1 data; 0 when disabled.
- mon_addr  in  ADDR_W  monitor address.
- mon_data  out  WIDTH  stored contents at mon_addr, always driven, never bypassed.
- wrap  out  1  registered one-cycle pulse: INC from all-ones or DEC from zero.

Behaviour:
- Reset (rst=0, asynchronous): every register = 0, wrap = 0, immediately and independent of clk. Release is synchronised by the integrator; the block samples normally on the first rising edge with rst=1.
- Write on rising clk edge when wr_en=1 and wr_addr < DEPTH. Next value:
  - LOAD: wr_data.
  - INC: old+1 mod 2^WIDTH.
  - DEC: old−1 mod 2^WIDTH.
  - CLEAR: 0.
- Exactly one register changes per cycle; all others hold.
- wr_en=0: no register changes, wrap goes 0 next edge.
- wr_addr ≥ DEPTH (non-power-of-two DEPTH only): write ignored, wrap = 0.
- wrap: registered; high for exactly the cycle after an INC of all-ones or a DEC of 0 to a valid address. Back-to-back wrapping ops give a continuous high, one cycle per op.
- Read ports are combinational, zero latency:
  - rdN_data = 0 when rdN_en=0 (no tri-state inside the core).
  - rdN_data = 0 when rdN_addr ≥ DEPTH.
  - Otherwise rdN_data = stored value.
- BYPASS=1: if wr_en=1, wr_addr valid, and rdN_addr == wr_addr, rdN_data = the computed next value (incl. INC/DEC/CLEAR result) in the same cycle.
- BYPASS=0: read ports return the pre-edge stored value.
- Both read ports may address the same register; each behaves independently.
- mon_data = stored value at mon_addr (0 if out of range), never bypassed, ignores all enables.
- No combinational path from wr_* to mon_data or wrap. With BYPASS=0, no combinational path from wr_* to rd*_data either.
- Reset asserted mid-write: reset wins; the register holds 0, wrap = 0.

Decomposition:
- Shared package reg_bank_pkg: wr_op enum (OP_LOAD, OP_INC, OP_DEC, OP_CLEAR) and a function computing next value plus wrap flag from (op, old, data). This function is reused by other counter-style components.
- Natural sub-module register_plus_cell: one WIDTH register with async active-low reset, select, op, data.
  - Outputs: stored value, next value, wrap condition.
  - Instantiated DEPTH times via generate.
- Read muxes, bypass logic and the wrap register live in the top module.

Test Plan:
- Reset then read: after reset, rd0_en=1 for each address 0..7, and mon_addr swept over 0..7 -> rd0_data = 0, mon_data = 0, wrap = 0.
- Load/readback, disabled port: LOAD 0xA5 to r3, then rd0_en=1, rd0_addr=3, rd1_en=0, rd1_addr=3 -> rd0_data = 0xA5, rd1_data = 0.
- Counter wrap: LOAD 0xFE to r1, INC r1 twice -> r1 = 0xFF then 0x00, wrap high only the cycle after the second INC. Then DEC r1 -> r1 = 0xFF, wrap high one cycle.
- Bypass (BYPASS=1): r2 = 0x10; in the same cycle wr_en=1 INC r2 with rd1_addr=2, rd1_en=1, mon_addr=2 -> rd1_data = 0x11 and mon_data = 0x10 that cycle; both = 0x11 after the edge. Repeat with BYPASS=0 -> rd1_data = 0x10 during the write cycle.
- Non-power-of-two DEPTH=5, WIDTH=4: LOAD 0x7 to addr 6, reads of addr 5..7 -> no register changes, rdN_data = 0, wrap = 0. CLEAR to r4 after LOAD 0xF -> r4 = 0.
- Async reset mid-op: r0 = 0x33; pull rst low between clock edges while wr_en=1 LOAD 0x44 to r0 -> r0 and mon_data = 0 immediately. After release and one edge with wr_en=0, r0 remains 0.
